serial_to_parallel_deser: RTL and testbench
===========================================

Name: serial_to_parallel_deser

Overview:
Serial-to-parallel deserializer, the receive-side counterpart of the team's bit-select/serializer path. It accepts one bit per handshake, LSB first, and assembles each frame into a WIDTH-bit word. The word is presented on a registered valid/ready output with a one-word buffer, so frame collection continues while the consumer is stalled. It sits between a bit-level link and a word-level consumer.

Parameters:
WIDTH, 8, data bits per word (>=2)

Ports:
clk  input  1  clock
rst  input  1  synchronous active-high reset
serial_valid  input  1  serial bit present
serial_data  input  1  serial bit, LSB of word first
serial_ready  output  1  deserializer accepts bit this cycle
parallel_valid  output  1  assembled word available
parallel_data  output  WIDTH  assembled word
parallel_ready  input  1  consumer accepts word this cycle
parity_err  output  1  parity flag, qualified by parallel_valid

Behaviour:
- Interface: one clock, clk; reset is synchronous and active-high, rst.
- FRAME_LEN = WIDTH+1 with PARITY_CHECK_EN, otherwise WIDTH. LAST = FRAME_LEN-1.
- State:
  - bit counter cnt, 0..LAST, width $clog2(FRAME_LEN);
  - shift register sh[WIDTH-1:0];
  - running parity rp;
  - output buffer (out_valid, out_data, out_err).
- Serial accept happens when serial_valid && serial_ready.
  - Data bit (cnt<WIDTH): sh <= {serial_data, sh[WIDTH-1:1]}, so the word is LSB first.
  - Parity bit (cnt==WIDTH, feature on): consumed only into rp, never shifted into sh.
  - Every accepted bit: rp <= rp ^ serial_data.
  - cnt increments, wrapping LAST->0.
- serial_ready = !(out_valid && cnt==LAST).
  - Purely registered-state driven; no combinational path from parallel_ready.
  - Consequence: a full buffer stalls only the final bit of the next frame.
- Load, on accept at cnt==LAST:
  - out_data <= final word, including the bit just accepted when the feature is off;
  - out_err <= final parity;
  - out_valid <= 1;
  - cnt <= 0, rp <= 0.
- Latency: parallel_valid rises on the cycle after the last bit is accepted.
- Output handshake: parallel_valid && parallel_ready clears out_valid next cycle.
  - parallel_data and parity_err hold stable while valid && !ready.
- Load and drain never coincide, because a load requires out_valid==0.
- Idle cycles (serial_valid=0) leave all state unchanged. Gaps are allowed anywhere in a frame.
- Throughput: one word per FRAME_LEN accepted bits with no stall when parallel_ready is held 1.
- Reset values:
  - serial_ready=1, parallel_valid=0, parallel_data=0, parity_err=0;
  - cnt=0, sh=0, rp=0.
- Reset mid-frame discards the partial frame and any buffered word. The next accepted bit is bit 0.
- parallel_data is don't-care to consumers when parallel_valid=0, but is driven from out_data (never X after reset).

Optional Feature:
PARITY_CHECK_EN
- Defined:
  - frame is WIDTH data bits followed by one even-parity bit;
  - parity_err = XOR of all WIDTH+1 frame bits. It is 1 on an odd count of ones and is delivered with the word.
- Undefined:
  - frame is WIDTH bits;
  - parity_err tied 0;
  - rp logic is removed;
  - port list is unchanged.

Decomposition:
- Package deser_pkg:
  - localparam helper frame_len(width, parity_en);
  - cnt width constant;
  - enum for counter phase {DATA, PARITY} used in assertions.
- One natural sub-module: out_buffer_1w, a single-entry valid/ready holding register with load/drain ports and reset.
- Shift and count logic stays in the top level.

Test Plan:
1. Feature on, WIDTH=8, ready=1, send bits 1,0,1,0,0,1,0,1 then parity 0 -> one cycle after the 9th accept: parallel_valid=1, data=0xA5, parity_err=0.
2. Feature on, send 0x01 (1,0,0,0,0,0,0,0) with parity bit 0 -> data=0x01, parity_err=1. Feature off, same 8 bits -> data=0x01, parity_err=0, valid one cycle after the 8th bit.
3. parallel_ready=0, send 0x3C then all of 0xC3 -> serial_ready drops with cnt==LAST of frame 2, 0x3C held stable. Raise ready for one cycle -> 0x3C accepted, serial_ready=1 one cycle later, final bit accepted, next word 0xC3.
4. Random serial_valid gaps (about 50% idle) while sending 0x5A with correct parity -> data=0x5A, err=0, identical to gap-free result.
5. Send 4 bits of 0x0F, pulse rst one cycle, send full 0xFF with parity 0 -> data=0xFF, err=0, no residue; all outputs at reset values during and after rst.
6. Ten back-to-back frames 0x00..0x09, serial_valid=1, parallel_ready=1 -> serial_ready never drops, words in order, one valid pulse every FRAME_LEN cycles.

Source files
------------

// File: rtl/deser_pkg.sv
// Shared constants and helpers for the serial-to-parallel deserializer.
// PARITY_CHECK_EN selects the WIDTH+1 bit frame with a trailing even-parity bit.
package deser_pkg;

`ifdef PARITY_CHECK_EN
  localparam bit PARITY_EN = 1'b1;
`else
  localparam bit PARITY_EN = 1'b0;
`endif

  typedef enum logic {
    PH_DATA   = 1'b0,
    PH_PARITY = 1'b1
  } phase_e;

  function automatic int frame_len(input int width, input bit parity_en);
    return parity_en ? width + 1 : width;
  endfunction

  function automatic int cnt_width(input int width, input bit parity_en);
    return $clog2(frame_len(width, parity_en));
  endfunction

endpackage

// File: rtl/serial_to_parallel_deser_out_buffer.sv
// Single-entry valid/ready holding register: load when empty, drain on valid && ready.
// Data and error flag stay stable while valid is high and the consumer stalls.
module out_buffer_1w #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_load_data,
  input  logic             i_load_err,
  input  logic             i_rdy,
  output logic             o_vld,
  output logic [WIDTH-1:0] o_dat,
  output logic             o_err
);

  logic             r_vld;
  logic [WIDTH-1:0] r_dat;
  logic             r_err;
  logic             w_drain;

  assign w_drain = r_vld && i_rdy;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_vld <= 1'b0;
      r_dat <= '0;
      r_err <= 1'b0;
    end else if (i_load) begin
      r_vld <= 1'b1;
      r_dat <= i_load_data;
      r_err <= i_load_err;
    end else if (w_drain) begin
      r_vld <= 1'b0;
    end
  end

  // The producer only loads into an empty buffer, so load and drain never overlap.
  always @(posedge clk) begin
    if (!rst) begin
      assert (!(i_load && r_vld));
    end
  end

  assign o_vld = r_vld;
  assign o_dat = r_dat;
  assign o_err = r_err;

endmodule

// File: rtl/serial_to_parallel_deser.sv
// LSB-first serial-to-parallel deserializer with a registered one-word output buffer.
// Macro PARITY_CHECK_EN adds a trailing even-parity bit per frame and drives parity_err.
module serial_to_parallel_deser
  import deser_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             serial_valid,
  input  logic             serial_data,
  output logic             serial_ready,
  output logic             parallel_valid,
  output logic [WIDTH-1:0] parallel_data,
  input  logic             parallel_ready,
  output logic             parity_err
);

  localparam int FRAME_LEN = frame_len(WIDTH, PARITY_EN);
  localparam int CNT_W     = cnt_width(WIDTH, PARITY_EN);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(FRAME_LEN - 1);

  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_sh;
  logic             w_last;
  logic             w_accept;
  logic             w_load;
  logic [WIDTH-1:0] w_word;
  logic             w_err;
  phase_e           w_phase;

  assign w_last   = (r_cnt == LAST);
  // Only the final bit of a frame waits on a full buffer; earlier bits keep flowing.
  assign serial_ready = !(parallel_valid && w_last);
  assign w_accept = serial_valid && serial_ready;
  assign w_load   = w_accept && w_last;
  assign w_phase  = (PARITY_EN && (r_cnt == CNT_W'(WIDTH))) ? PH_PARITY : PH_DATA;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
      r_sh  <= '0;
    end else if (w_accept) begin
      if (w_phase == PH_DATA) begin
        r_sh <= {serial_data, r_sh[WIDTH-1:1]};
      end
      r_cnt <= w_last ? '0 : r_cnt + CNT_W'(1);
    end
  end

`ifdef PARITY_CHECK_EN
  logic r_rp;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rp <= 1'b0;
    end else if (w_accept) begin
      r_rp <= w_last ? 1'b0 : (r_rp ^ serial_data);
    end
  end

  assign w_err  = r_rp ^ serial_data;
  assign w_word = r_sh;
`else
  // The last data bit goes straight into the loaded word, bypassing the shifter.
  assign w_err  = 1'b0;
  assign w_word = {serial_data, r_sh[WIDTH-1:1]};
`endif

  out_buffer_1w #(
    .WIDTH(WIDTH)
  ) u_out_buffer (
    .clk        (clk),
    .rst        (rst),
    .i_load     (w_load),
    .i_load_data(w_word),
    .i_load_err (w_err),
    .i_rdy      (parallel_ready),
    .o_vld      (parallel_valid),
    .o_dat      (parallel_data),
    .o_err      (parity_err)
  );

  always @(posedge clk) begin
    if (!rst) begin
      assert (PARITY_EN || (w_phase == PH_DATA));
      assert (!(w_load && parallel_valid));
    end
  end

endmodule

// File: tb/tb_serial_to_parallel_deser.sv
// Scoreboard bench: drivers queue expected words, a negedge monitor pops on each handshake.
module tb_serial_to_parallel_deser;

  localparam int W = 8;
`ifdef PARITY_CHECK_EN
  localparam bit PE = 1'b1;
`else
  localparam bit PE = 1'b0;
`endif
  localparam int FL = PE ? W + 1 : W;

  typedef struct packed {
    logic [W-1:0] d;
    logic         e;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst;
  logic         serial_valid;
  logic         serial_data;
  logic         serial_ready;
  logic         parallel_valid;
  logic [W-1:0] parallel_data;
  logic         parallel_ready;
  logic         parity_err;

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   stalls = 0;
  exp_t exp_q[$];
  int   pop_t[$];
  exp_t mon_e;
  logic hold_chk = 1'b0;
  logic [W-1:0] hold_d;
  logic hold_e;
  bit   rnd_ready = 1'b0;

  serial_to_parallel_deser #(.WIDTH(W)) dut (
    .clk           (clk),
    .rst           (rst),
    .serial_valid  (serial_valid),
    .serial_data   (serial_data),
    .serial_ready  (serial_ready),
    .parallel_valid(parallel_valid),
    .parallel_data (parallel_data),
    .parallel_ready(parallel_ready),
    .parity_err    (parity_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  // Reference: the word is the data bits as sent; the flag is the odd/even count of ones.
  function automatic exp_t model(input logic [W-1:0] word, input logic pbit);
    exp_t r;
    int   ones;
    ones = 0;
    for (int i = 0; i < W; i++) ones += int'(word[i]);
    r.d = word;
    r.e = PE ? (((ones + int'(pbit)) % 2) == 1) : 1'b0;
    return r;
  endfunction

  task automatic idle(input int n);
    serial_valid = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_bit(input logic b);
    int n;
    n = 0;
    serial_valid = 1'b1;
    serial_data  = b;
    @(negedge clk);
    while (!serial_ready && n < 500) begin
      stalls++;
      n++;
      @(negedge clk);
    end
    if (n >= 500) chk("serial_ready_timeout", serial_ready, 1);
    @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [W-1:0] word, input logic bad, input int gap_pct,
                            input bit lat_chk);
    logic       pbit;
    logic [W:0] fb;
    pbit = (^word) ^ bad;
    fb   = {pbit, word};
    exp_q.push_back(model(word, pbit));
    for (int i = 0; i < FL; i++) begin
      if (gap_pct > 0 && $urandom_range(0, 99) < gap_pct) idle($urandom_range(1, 3));
      if (lat_chk && i == FL - 1) chk("valid_before_last_bit", parallel_valid, 0);
      send_bit(fb[i]);
    end
    if (lat_chk) chk("valid_one_cycle_after_last", parallel_valid, 1);
  endtask

  always @(negedge clk) begin
    if (rst) begin
      hold_chk = 1'b0;
    end else begin
      if (hold_chk) begin
        chk("hold_valid", parallel_valid, 1);
        chk("hold_data", parallel_data, hold_d);
        chk("hold_err", parity_err, hold_e);
      end
      if (parallel_valid && parallel_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_word", parallel_valid, 0);
        end else begin
          mon_e = exp_q.pop_front();
          chk("word_data", parallel_data, mon_e.d);
          chk("word_err", parity_err, mon_e.e);
          pop_t.push_back(cyc);
        end
      end
      hold_chk = parallel_valid && !parallel_ready;
      hold_d   = parallel_data;
      hold_e   = parity_err;
    end
  end

  always @(posedge clk) begin
    if (rnd_ready) begin
      #1;
      parallel_ready = 1'($urandom_range(0, 1));
    end
  end

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_serial_ready"}, serial_ready, 1);
    chk({tag, "_parallel_valid"}, parallel_valid, 0);
    chk({tag, "_parallel_data"}, parallel_data, 0);
    chk({tag, "_parity_err"}, parity_err, 0);
  endtask

  initial begin
    logic [W-1:0] w2;
    logic [W:0]   fb2;
    int           n;

    rst = 1'b1;
    serial_valid = 1'b0;
    serial_data = 1'b0;
    parallel_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk_reset_outputs("reset");
    rst = 1'b0;
    idle(1);

    // Directed frames with exact latency checks.
    send_frame(8'hA5, 1'b0, 0, 1'b1);
    idle(2);
    send_frame(8'h01, 1'b1, 0, 1'b1);
    idle(2);

    // Stalled consumer: the second frame's final bit must wait for the drain.
    parallel_ready = 1'b0;
    send_frame(8'h3C, 1'b0, 0, 1'b1);
    w2  = 8'hC3;
    fb2 = {^w2, w2};
    exp_q.push_back(model(w2, fb2[W]));
    for (int i = 0; i < FL - 1; i++) send_bit(fb2[i]);
    serial_valid = 1'b1;
    serial_data  = fb2[FL-1];
    @(negedge clk);
    chk("stall_serial_ready_low", serial_ready, 0);
    repeat (3) @(negedge clk);
    chk("stall_still_low", serial_ready, 0);
    chk("stall_held_data", parallel_data, 8'h3C);
    @(posedge clk);
    #1;
    parallel_ready = 1'b1;
    @(posedge clk);
    #1;
    parallel_ready = 1'b0;
    chk("drain_serial_ready_back", serial_ready, 1);
    chk("drain_valid_cleared", parallel_valid, 0);
    @(posedge clk);
    #1;
    serial_valid = 1'b0;
    chk("second_word_valid", parallel_valid, 1);
    chk("second_word_data", parallel_data, 8'hC3);
    parallel_ready = 1'b1;
    idle(3);

    // Gapped frame must match a gap-free one.
    send_frame(8'h5A, 1'b0, 50, 1'b1);
    idle(2);

    // Reset mid-frame discards the partial word.
    for (int i = 0; i < 4; i++) send_bit(1'b1);
    serial_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk_reset_outputs("mid_reset");
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk_reset_outputs("post_reset");
    send_frame(8'hFF, 1'b0, 0, 1'b1);
    idle(2);

    // Back-to-back frames at full rate.
    pop_t.delete();
    stalls = 0;
    for (int k = 0; k < 10; k++) send_frame(W'(k), 1'b0, 0, 1'b0);
    idle(3);
    chk("b2b_no_stall", stalls, 0);
    chk("b2b_word_count", pop_t.size(), 10);
    if (pop_t.size() == 10) begin
      for (int i = 1; i < 10; i++) chk("b2b_spacing", pop_t[i] - pop_t[i-1], FL);
    end

    // Random words, parity faults, gaps and consumer stalls.
    rnd_ready = 1'b1;
    for (int k = 0; k < 30; k++) begin
      send_frame(W'($urandom), 1'($urandom_range(0, 3) == 0), 30, 1'b0);
    end
    serial_valid = 1'b0;
    rnd_ready = 1'b0;
    @(posedge clk);
    #1;
    parallel_ready = 1'b1;
    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("final_queue_empty", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog_timeout actual=%0d required=finish", cyc);
    $fatal(1, "watchdog");
  end

endmodule
